iscas_resp_misr: RTL and testbench
==================================

ISCAS_RESP_MISR -- requirements
Module: iscas_resp_misr

Interface
REQ-001 SHALL have parameter WIDTH, default 19; number of benchmark response bits compacted per sample.
REQ-002 SHALL have parameter SIG_W, default 24; signature width, SIG_W > WIDTH required.
REQ-003 SHALL have parameter POLY, default 24'hC20001 (x^24+x^23+x^22+x^17+1, x^24 implicit); feedback taps.
REQ-004 SHALL have parameter SKIP, default 5; warm-up samples discarded per run (flushes benchmark flip-flops).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: ports clk and rst_n; all state SHALL reset asynchronously when rst_n is low.
REQ-006 SHALL have port clk, input, 1 bit; rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit; single-cycle run request.
REQ-009 SHALL have port abort, input, 1 bit; cancels the current run.
REQ-010 SHALL have port num_samples, input, 16 bits; compacted-sample count, sampled on accepted start.
REQ-011 SHALL have port expected, input, SIG_W bits; golden signature, compared combinationally in DONE.
REQ-012 SHALL have port dut_valid, input, 1 bit; dut_out carries a valid response this cycle.
REQ-013 SHALL have port dut_out, input, WIDTH bits; benchmark primary outputs.
REQ-014 SHALL have port busy, output, 1 bit; high in SKIP or RUN.
REQ-015 SHALL have port done, output, 1 bit; high in DONE.
REQ-016 SHALL have port signature, output, SIG_W bits; current MISR register.
REQ-017 SHALL have port pass, output, 1 bit; done && (signature == expected).

Function
REQ-018 SHALL implement FSM states IDLE, SKIP, RUN, DONE.
REQ-019 IDLE/DONE + start (abort low) SHALL, next edge: signature<=0, skip counter<=0, sample counter<=0, latch num_samples, enter SKIP (or RUN if SKIP==0).
REQ-020 start while busy SHALL be ignored.
REQ-021 In SKIP, each dut_valid cycle SHALL increment skip counter; after SKIP valid samples, enter RUN; signature unchanged.
REQ-022 In RUN, each dut_valid cycle SHALL update signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended dut_out, and increment sample counter.
REQ-023 RUN SHALL enter DONE on the edge that consumes sample num_samples; signature final on that edge (latency 0 after last sample).
REQ-024 num_samples==0 SHALL enter DONE directly from the end of SKIP (or from IDLE when SKIP==0) with signature 0.
REQ-025 dut_valid low SHALL hold all counters and signature (stall).
REQ-026 abort SHALL, next edge, return any state to IDLE with signature held; done/pass low.
REQ-027 abort and start in the same cycle: abort SHALL win.
REQ-028 DONE SHALL hold signature and done until start or abort.
REQ-029 Counters SHALL be 16 bits; no wrap possible within a run.

Reset
REQ-030 On rst_n low: state IDLE, signature 0, counters 0, busy 0, done 0, pass 0.
REQ-031 Reset mid-run SHALL discard the run; no done pulse after release.

Structure
REQ-032 FSM state enum and default POLY/SKIP constants SHALL live in shared package iscas_tb_pkg.
REQ-033 MISR update SHALL be one sub-module misr_step (combinational next-signature function, parameters SIG_W, WIDTH, POLY).

Verification
REQ-034 SKIP=0, num_samples=1, dut_out=19'h00001 valid -> DONE, signature 24'h000001.
REQ-035 SKIP=0, num_samples=2, dut_out=19'h00001 twice -> signature 24'h000003; expected=24'h000003 -> pass=1; expected=24'h000004 -> pass=0.
REQ-036 SKIP=0, num_samples=7, samples 19'h40000 then six 0 -> signature 24'hC20001 (feedback path).
REQ-037 SKIP=5, num_samples=1, five 19'h7FFFF then 19'h00002, dut_valid low for 3 cycles between -> signature 24'h000002, busy held through stalls.
REQ-038 abort asserted with start mid-RUN -> IDLE next edge, done=0; rst_n low mid-SKIP -> all outputs 0 immediately.
REQ-039 num_samples=0, SKIP=0 -> done one edge after start, signature 0; start while busy -> ignored, counters unchanged.

Source files
------------

// File: rtl/iscas_tb_pkg.sv
// Shared types and default constants for the ISCAS response MISR.
package iscas_tb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSkip = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } misr_state_e;

    // x^24 + x^23 + x^22 + x^17 + 1, with the x^24 term implicit
    localparam logic [23:0] DefPoly = 24'hC20001;

    // Warm-up samples that flush the benchmark flip-flops before compaction
    localparam int unsigned DefSkip = 5;

endpackage

// File: rtl/misr_step.sv
// Combinational next-signature function of the MISR: shift, polynomial feedback, data fold-in.
module misr_step
    import iscas_tb_pkg::*;
#(
    parameter int unsigned      SIG_W = 24,
    parameter int unsigned      WIDTH = 19,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefPoly)
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic [WIDTH-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] w_shift;
    logic [SIG_W-1:0] w_fb;
    logic [SIG_W-1:0] w_data;

    assign w_shift = {i_sig[SIG_W-2:0], 1'b0};
    // Feedback applies when the bit shifted out of the top is set
    assign w_fb    = i_sig[SIG_W-1] ? POLY : '0;
    assign w_data  = SIG_W'(i_data);
    assign o_sig   = w_shift ^ w_fb ^ w_data;

endmodule

// File: rtl/iscas_resp_misr.sv
// Response compactor for ISCAS benchmarks: discards SKIP warm-up samples, then folds
// num_samples valid responses into a MISR signature and compares it against a golden value.
module iscas_resp_misr
    import iscas_tb_pkg::*;
#(
    parameter int unsigned      WIDTH = 19,
    parameter int unsigned      SIG_W = 24,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefPoly),
    parameter int unsigned      SKIP  = DefSkip
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      num_samples,
    input  logic [SIG_W-1:0] expected,
    input  logic             dut_valid,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    // Skip count value that marks the final warm-up sample (unused when SKIP is 0)
    localparam logic [15:0] SkipLast = 16'(SKIP - 1);

    misr_state_e      r_state;
    logic [SIG_W-1:0] r_sig;
    logic [15:0]      r_skip_cnt;
    logic [15:0]      r_smp_cnt;
    logic [15:0]      r_num;
    logic [SIG_W-1:0] w_sig_next;

    misr_step #(
        .SIG_W (SIG_W),
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_step (
        .i_sig  (r_sig),
        .i_data (dut_out),
        .o_sig  (w_sig_next)
    );

    // Run control FSM with counters and signature register; abort overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_sig      <= '0;
            r_skip_cnt <= '0;
            r_smp_cnt  <= '0;
            r_num      <= '0;
        end else if (abort) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_sig      <= '0;
                        r_skip_cnt <= '0;
                        r_smp_cnt  <= '0;
                        r_num      <= num_samples;
                        if (SKIP != 0) begin
                            r_state <= StSkip;
                        end else if (num_samples == '0) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StSkip: begin
                    if (dut_valid) begin
                        r_skip_cnt <= r_skip_cnt + 16'd1;
                        if (r_skip_cnt == SkipLast) begin
                            r_state <= (r_num == '0) ? StDone : StRun;
                        end
                    end
                end
                StRun: begin
                    if (dut_valid) begin
                        r_sig     <= w_sig_next;
                        r_smp_cnt <= r_smp_cnt + 16'd1;
                        // Final sample lands in the signature on the same edge we finish
                        if (r_smp_cnt + 16'd1 == r_num) begin
                            r_state <= StDone;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy      = (r_state == StSkip) || (r_state == StRun);
    assign done      = (r_state == StDone);
    assign signature = r_sig;
    assign pass      = done && (r_sig == expected);

endmodule

// File: tb/tb_iscas_resp_misr.sv
// Self-checking bench: two instances (SKIP=0 and SKIP=5) share one stimulus stream;
// expected signatures are queued when samples are driven and popped when done rises.
module tb_iscas_resp_misr;

    localparam int unsigned W  = 19;
    localparam int unsigned SW = 24;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          start       = 1'b0;
    logic          abort       = 1'b0;
    logic [15:0]   num_samples = '0;
    logic [SW-1:0] expected    = '0;
    logic          dut_valid   = 1'b0;
    logic [W-1:0]  dut_out     = '0;

    logic          busy0, done0, pass0;
    logic [SW-1:0] sig0;
    logic          busy5, done5, pass5;
    logic [SW-1:0] sig5;

    int n_checks = 0;
    int n_errors = 0;

    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] m_sig;

    always #5 clk = ~clk;

    iscas_resp_misr #(
        .WIDTH (W),
        .SIG_W (SW),
        .POLY  (24'hC20001),
        .SKIP  (0)
    ) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_samples (num_samples),
        .expected    (expected),
        .dut_valid   (dut_valid),
        .dut_out     (dut_out),
        .busy        (busy0),
        .done        (done0),
        .signature   (sig0),
        .pass        (pass0)
    );

    iscas_resp_misr #(
        .WIDTH (W),
        .SIG_W (SW),
        .POLY  (24'hC20001),
        .SKIP  (5)
    ) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_samples (num_samples),
        .expected    (expected),
        .dut_valid   (dut_valid),
        .dut_out     (dut_out),
        .busy        (busy5),
        .done        (done5),
        .signature   (sig5),
        .pass        (pass5)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Reference MISR step written straight from the update equation
    function automatic logic [SW-1:0] model_step(input logic [SW-1:0] s, input logic [W-1:0] d);
        logic [SW-1:0] n;
        n = {s[SW-2:0], 1'b0};
        if (s[SW-1]) n = n ^ 24'hC20001;
        return n ^ {{(SW-W){1'b0}}, d};
    endfunction

    // All stimulus tasks are entered and left at a falling edge
    task automatic start_run(input logic [15:0] n);
        start       = 1'b1;
        num_samples = n;
        m_sig       = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        dut_valid = 1'b1;
        dut_out   = d;
        m_sig     = model_step(m_sig, d);
        @(negedge clk);
        dut_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit sel5);
        for (int i = 0; i < 20; i++) begin
            if ((sel5 ? done5 : done0) === 1'b1) break;
            @(negedge clk);
        end
        check_val(tag, sel5 ? done5 : done0, 1'b1);
    endtask

    task automatic sb_check(input string tag, input logic [SW-1:0] act);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hxxxxxxxx;
        check_val(tag, 32'(act), e);
    endtask

    initial begin
        m_sig = '0;
        repeat (3) @(negedge clk);
        check_val("rst_sig0", sig0, 0);
        check_val("rst_busy0", busy0, 0);
        check_val("rst_done0", done0, 0);
        check_val("rst_pass0", pass0, 0);
        check_val("rst_busy5", busy5, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sample, zero-latency completion
        start_run(16'd1);
        check_val("t34_busy", busy0, 1);
        send(19'h00001);
        exp_q.push_back(m_sig);
        check_val("t34_done_now", done0, 1);
        sb_check("t34_sig_model", sig0);
        check_val("t34_sig_const", sig0, 24'h000001);
        do_abort();

        // Two samples and the pass comparison
        start_run(16'd2);
        send(19'h00001);
        check_val("t35_not_done", done0, 0);
        send(19'h00001);
        exp_q.push_back(m_sig);
        wait_done("t35_done", 1'b0);
        sb_check("t35_sig_model", sig0);
        check_val("t35_sig_const", sig0, 24'h000003);
        expected = 24'h000003;
        #1 check_val("t35_pass", pass0, 1);
        expected = 24'h000004;
        #1 check_val("t35_nopass", pass0, 0);
        repeat (3) @(negedge clk);
        check_val("t35_hold_done", done0, 1);
        check_val("t35_hold_sig", sig0, 24'h000003);
        do_abort();

        // Feedback path
        start_run(16'd7);
        send(19'h40000);
        for (int i = 0; i < 6; i++) send(19'h00000);
        exp_q.push_back(m_sig);
        wait_done("t36_done", 1'b0);
        sb_check("t36_sig_model", sig0);
        check_val("t36_sig_const", sig0, 24'hC20001);
        do_abort();

        // Warm-up discard with stalls on the SKIP=5 instance
        start_run(16'd1);
        check_val("t37_busy_start", busy5, 1);
        for (int i = 0; i < 5; i++) send(19'h7FFFF);
        for (int i = 0; i < 3; i++) begin
            check_val("t37_busy_stall", busy5, 1);
            check_val("t37_sig_stall", sig5, 0);
            @(negedge clk);
        end
        exp_q.push_back(model_step('0, 19'h00002));
        send(19'h00002);
        wait_done("t37_done", 1'b1);
        sb_check("t37_sig_model", sig5);
        check_val("t37_sig_const", sig5, 24'h000002);
        do_abort();

        // Abort together with start mid-run
        start_run(16'd4);
        send(19'h00005);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_val("t38_abort_busy", busy0, 0);
        check_val("t38_abort_done", done0, 0);
        check_val("t38_abort_sig", sig0, model_step('0, 19'h00005));

        // Asynchronous reset in the middle of warm-up
        start_run(16'd3);
        send(19'h00001);
        check_val("t38_busy5_pre", busy5, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t38_rst_busy5", busy5, 0);
        check_val("t38_rst_busy0", busy0, 0);
        check_val("t38_rst_sig0", sig0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(19'h00003);
            check_val("t38_no_done5", done5, 0);
        end
        check_val("t38_no_done0", done0, 0);

        // Zero-sample run finishes one edge after start
        start_run(16'd0);
        check_val("t39_done0", done0, 1);
        check_val("t39_sig0", sig0, 0);
        expected = 24'h000000;
        #1 check_val("t39_pass0", pass0, 1);
        do_abort();

        // Start while busy is ignored: original count of 3 stays in force
        start_run(16'd3);
        send(19'h00001);
        start_run(16'd1);
        m_sig = model_step('0, 19'h00001);
        send(19'h00001);
        check_val("t39_ignored", done0, 0);
        send(19'h00001);
        exp_q.push_back(m_sig);
        check_val("t39_done_late", done0, 1);
        sb_check("t39_sig_model", sig0);
        check_val("t39_sig_const", sig0, 24'h000007);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
